// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI link register-access engine.
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_STP,
        ST_TURN,
        ST_RDATA,
        ST_WAIT_LOW,
        ST_HOLD
    } state_e;

    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;
    localparam logic [7:0] NOOP       = 8'h00;

    typedef struct packed {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
    } reg_req_t;

    function automatic logic [7:0] reg_cmd(input logic wr, input logic [5:0] addr);
        return {wr ? TXCMD_REGW : TXCMD_REGR, addr};
    endfunction

endpackage

// File: rtl/ulpi_link_reg_if.sv
// ULPI bus plus register request/response signals; master = link, slave = PHY/user side.
interface ulpi_link_reg_if;

    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_direction;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;

    modport master (
        input  ulpi_data_in, ulpi_direction, ulpi_nxt,
        input  req_valid, req_wr, req_addr, req_wdata,
        output ulpi_data_out, ulpi_data_oe, ulpi_stp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output rx_cmd_valid, rx_cmd
    );

    modport slave (
        output ulpi_data_in, ulpi_direction, ulpi_nxt,
        output req_valid, req_wr, req_addr, req_wdata,
        input  ulpi_data_out, ulpi_data_oe, ulpi_stp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  rx_cmd_valid, rx_cmd
    );

endinterface

// File: rtl/ulpi_timeout_cnt.sv
// Per-state cycle counter; expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module ulpi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/ulpi_link_reg.sv
// ULPI link register read/write engine with abort/reissue and timeout handling.
// Define ULPI_LINK_RXCMD_EN to build RX CMD capture; otherwise rx_cmd outputs are tied low.
module ulpi_link_reg
    import ulpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            ulpi_clk,
    input  logic            ulpi_reset,
    ulpi_link_reg_if.master bus
);

    state_e     state;
    state_e     next_state;
    reg_req_t   req_q;
    logic       dir_d;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_expired;
    logic       rsp_fire;
    logic       rsp_fire_err;
    logic [7:0] rsp_fire_rdata;

    // The bus is ours only when the PHY has not owned it this cycle or the last.
    assign bus.ulpi_data_oe = !bus.ulpi_direction && !dir_d;
    assign bus.req_ready    = (state == ST_IDLE) && !bus.ulpi_direction && !dir_d;

    assign cnt_enable = state inside {ST_CMD, ST_WDATA, ST_TURN};
    assign cnt_clear  = (next_state != state);

    ulpi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (ulpi_clk),
        .rst    (ulpi_reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    always_ff @(posedge ulpi_clk) begin
        if (ulpi_reset) begin
            state         <= ST_IDLE;
            dir_d         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            state         <= next_state;
            dir_d         <= bus.ulpi_direction;
            bus.rsp_valid <= rsp_fire;
            bus.rsp_err   <= rsp_fire_err;
            bus.rsp_rdata <= rsp_fire_rdata;
        end
    end

    // NOTE: the request latch needs no reset; it is only read after a request has been accepted.
    always_ff @(posedge ulpi_clk) begin
        if (bus.req_valid && bus.req_ready) begin
            req_q <= '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next_state        = state;
        bus.ulpi_data_out = NOOP;
        bus.ulpi_stp      = 1'b0;
        rsp_fire          = 1'b0;
        rsp_fire_err      = 1'b0;
        rsp_fire_rdata    = '0;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) next_state = ST_CMD;
            end
            ST_CMD: begin
                bus.ulpi_data_out = reg_cmd(req_q.wr, req_q.addr);
                if (bus.ulpi_nxt) begin
                    next_state = req_q.wr ? ST_WDATA : ST_TURN;
                end else if (bus.ulpi_direction) begin
                    next_state = ST_HOLD;
                end else if (cnt_expired) begin
                    rsp_fire     = 1'b1;
                    rsp_fire_err = 1'b1;
                    next_state   = req_q.wr ? ST_STP : ST_WAIT_LOW;
                end
            end
            ST_WDATA: begin
                bus.ulpi_data_out = req_q.wdata;
                if (bus.ulpi_nxt) begin
                    rsp_fire   = 1'b1;
                    next_state = ST_STP;
                end else if (bus.ulpi_direction) begin
                    next_state = ST_HOLD;
                end else if (cnt_expired) begin
                    rsp_fire     = 1'b1;
                    rsp_fire_err = 1'b1;
                    next_state   = ST_STP;
                end
            end
            ST_STP: begin
                bus.ulpi_stp = 1'b1;
                next_state   = ST_IDLE;
            end
            ST_TURN: begin
                if (bus.ulpi_direction) begin
                    next_state = ST_RDATA;
                end else if (cnt_expired) begin
                    rsp_fire     = 1'b1;
                    rsp_fire_err = 1'b1;
                    next_state   = ST_WAIT_LOW;
                end
            end
            ST_RDATA: begin
                rsp_fire       = 1'b1;
                rsp_fire_rdata = bus.ulpi_data_in;
                next_state     = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!bus.ulpi_direction) next_state = ST_IDLE;
            end
            ST_HOLD: begin
                // Aborted attempt: reissue the whole command once the PHY lets go.
                if (!bus.ulpi_direction) next_state = ST_CMD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef ULPI_LINK_RXCMD_EN
    logic rx_hit;

    assign rx_hit = dir_d && bus.ulpi_direction && !bus.ulpi_nxt && (state != ST_RDATA);

    always_ff @(posedge ulpi_clk) begin
        if (ulpi_reset) begin
            bus.rx_cmd_valid <= 1'b0;
            bus.rx_cmd       <= '0;
        end else begin
            bus.rx_cmd_valid <= rx_hit;
            if (rx_hit) bus.rx_cmd <= bus.ulpi_data_in;
        end
    end
`else
    assign bus.rx_cmd_valid = 1'b0;
    assign bus.rx_cmd       = '0;
`endif

endmodule

// File: tb/tb_ulpi_link_reg.sv
// Bench for ulpi_link_reg: directed vector table, timeout/RX CMD sequences, random run vs model.
module tb_ulpi_link_reg;

    localparam int TIMEOUT = 64;
`ifdef ULPI_LINK_RXCMD_EN
    localparam bit RXEN = 1'b1;
`else
    localparam bit RXEN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ulpi_link_reg_if bus();

    ulpi_link_reg #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .ulpi_clk  (clk),
        .ulpi_reset(rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       rst;
        logic       req_valid;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic       dir;
        logic       nxt;
        logic [7:0] din;
    } in_t;

    typedef struct packed {
        logic [7:0] dout;
        logic       oe;
        logic       stp;
        logic       ready;
        logic       rv;
        logic       err;
        logic [7:0] rdata;
        logic       rxv;
        logic [7:0] rx;
    } out_t;

    typedef struct {
        in_t        in;
        logic [20:0] exp;   // {dout, oe, stp, ready, rsp_valid, rsp_err, rsp_rdata}
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input in_t v);
        @(negedge clk);
        rst                = v.rst;
        bus.req_valid      = v.req_valid;
        bus.req_wr         = v.wr;
        bus.req_addr       = v.addr;
        bus.req_wdata      = v.wdata;
        bus.ulpi_direction = v.dir;
        bus.ulpi_nxt       = v.nxt;
        bus.ulpi_data_in   = v.din;
        #1;
    endtask

    function automatic out_t sample();
        out_t o;
        o = '{dout: bus.ulpi_data_out, oe: bus.ulpi_data_oe, stp: bus.ulpi_stp,
              ready: bus.req_ready, rv: bus.rsp_valid, err: bus.rsp_err,
              rdata: bus.rsp_rdata, rxv: bus.rx_cmd_valid, rx: bus.rx_cmd};
        return o;
    endfunction

    // Reference model: a request becomes a list of bytes to push out; the PHY
    // accepts one byte per nxt, may steal the bus (restart the list), or stall.
    typedef enum int {M_IDLE, M_SEND, M_STOP, M_TURN, M_READ, M_DRAIN, M_HOLD} mphase_e;

    mphase_e    m_phase = M_IDLE;
    logic [7:0] m_tx[$];
    logic       m_wr;
    logic [5:0] m_addr;
    logic [7:0] m_wdata;
    int         m_age = 0;
    logic       m_dir_prev = 1'b0;
    logic       m_rv = 1'b0, m_err = 1'b0, m_rxv = 1'b0;
    logic [7:0] m_rdata = 8'h00, m_rx = 8'h00;

    task automatic m_load();
        m_tx.delete();
        m_tx.push_back({m_wr ? 2'b10 : 2'b11, m_addr});
        if (m_wr) m_tx.push_back(m_wdata);
    endtask

    function automatic out_t m_expect(input in_t v);
        out_t o;
        o.dout  = (m_phase == M_SEND) ? m_tx[0] : 8'h00;
        o.oe    = !v.dir && !m_dir_prev;
        o.stp   = (m_phase == M_STOP);
        o.ready = (m_phase == M_IDLE) && !v.dir && !m_dir_prev;
        o.rv    = m_rv;
        o.err   = m_err;
        o.rdata = m_rdata;
        o.rxv   = m_rxv;
        o.rx    = m_rx;
        return o;
    endfunction

    task automatic m_update(input in_t v);
        mphase_e np;
        bit      restart;
        bit      late;
        if (v.rst) begin
            m_phase = M_IDLE; m_tx.delete(); m_age = 0; m_dir_prev = 1'b0;
            m_rv = 1'b0; m_err = 1'b0; m_rdata = 8'h00; m_rxv = 1'b0; m_rx = 8'h00;
            return;
        end
        late    = (m_age >= TIMEOUT - 1);
        np      = m_phase;
        restart = 1'b0;
        m_rxv   = RXEN && v.dir && m_dir_prev && !v.nxt && (m_phase != M_READ);
        if (m_rxv) m_rx = v.din;
        m_rv = 1'b0; m_err = 1'b0; m_rdata = 8'h00;
        case (m_phase)
            M_IDLE: if (v.req_valid && !v.dir && !m_dir_prev) begin
                m_wr = v.wr; m_addr = v.addr; m_wdata = v.wdata;
                m_load();
                np = M_SEND;
            end
            M_SEND: begin
                if (v.nxt) begin
                    void'(m_tx.pop_front());
                    restart = 1'b1;
                    if (m_tx.size() == 0) begin
                        np   = m_wr ? M_STOP : M_TURN;
                        m_rv = m_wr;
                    end
                end else if (v.dir) begin
                    np = M_HOLD;
                end else if (late) begin
                    m_rv = 1'b1; m_err = 1'b1;
                    np = m_wr ? M_STOP : M_DRAIN;
                end
            end
            M_STOP:  np = M_IDLE;
            M_TURN: begin
                if (v.dir) np = M_READ;
                else if (late) begin m_rv = 1'b1; m_err = 1'b1; np = M_DRAIN; end
            end
            M_READ: begin m_rv = 1'b1; m_rdata = v.din; np = M_DRAIN; end
            M_DRAIN: if (!v.dir) np = M_IDLE;
            M_HOLD:  if (!v.dir) begin m_load(); np = M_SEND; end
            default: np = M_IDLE;
        endcase
        if (np != m_phase) restart = 1'b1;
        m_age      = restart ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
        m_phase    = np;
        m_dir_prev = v.dir;
    endtask

    function automatic vec_t mk(input logic r, input logic rq, input logic wr, input logic [5:0] a,
                                input logic [7:0] wd, input logic dir, input logic nxt, input logic [7:0] din,
                                input logic [7:0] dout, input logic oe, input logic stp, input logic rdy,
                                input logic rv, input logic err, input logic [7:0] rd);
        vec_t t;
        t.in  = '{rst: r, req_valid: rq, wr: wr, addr: a, wdata: wd, dir: dir, nxt: nxt, din: din};
        t.exp = {dout, oe, stp, rdy, rv, err, rd};
        return t;
    endfunction

    vec_t tbl[$];
    in_t  v;
    out_t o;
    out_t e;

    initial begin
        int stp_at;
        logic stp_rv, stp_err;

        // Write 0x0A <= 0x5A
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,1,1,6'h0A,8'h5A,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h8A,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'h8A,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'h5A,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,1,0,1,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        // Read 0x16, PHY returns 0xC3
        tbl.push_back(mk(0,1,0,6'h16,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'hD6,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'h00, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'hC3, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,0,0,0,1,0,8'hC3));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        // Read 0x16 aborted in CMD, reissued, then returns 0x3C
        tbl.push_back(mk(0,1,0,6'h16,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'hD6,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'h00, 8'hD6,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,1,8'h00, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'hD6,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'h00, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'h3C, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,0,0,0,1,0,8'h3C));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        // Write 0x3F <= 0xA5, reset while in WDATA
        tbl.push_back(mk(0,1,1,6'h3F,8'hA5,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'hBF,1,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,6'h00,8'h00,0,0,8'h00, 8'hA5,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        // Write 0x05 <= 0x77 aborted in WDATA, reissued from CMD
        tbl.push_back(mk(0,1,1,6'h05,8'h77,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'h85,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,1,0,8'h00, 8'h77,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,0,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'h85,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,1,8'h00, 8'h77,1,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,1,0,1,0,8'h00));
        tbl.push_back(mk(0,0,0,6'h00,8'h00,0,0,8'h00, 8'h00,1,0,1,0,0,8'h00));

        rst = 1'b1;
        v = '0;
        v.rst = 1'b1;
        drive(v); m_update(v);
        drive(v); m_update(v);

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            o = sample();
            check($sformatf("row%0d", i), 32'({o.dout, o.oe, o.stp, o.ready, o.rv, o.err, o.rdata}),
                  32'(tbl[i].exp));
            m_update(tbl[i].in);
        end

        // Write with nxt never asserted: CMD times out, one stp pulse carrying the error response.
        v = '0; v.req_valid = 1'b1; v.wr = 1'b1; v.addr = 6'h01; v.wdata = 8'h02;
        drive(v);
        check("timeout_accept", 32'(bus.req_ready), 32'(1));
        m_update(v);
        v = '0;
        stp_at = -1; stp_rv = 1'b0; stp_err = 1'b0;
        for (int i = 0; i < 200 && stp_at < 0; i++) begin
            drive(v);
            if (bus.ulpi_stp) begin
                stp_at = i; stp_rv = bus.rsp_valid; stp_err = bus.rsp_err;
            end
            m_update(v);
        end
        check("timeout_stp_cycle", 32'(stp_at), 32'(TIMEOUT));
        check("timeout_rsp_valid", 32'(stp_rv), 32'(1));
        check("timeout_rsp_err", 32'(stp_err), 32'(1));
        drive(v);
        check("timeout_stp_single", 32'({bus.ulpi_stp, bus.rsp_valid, bus.req_ready}), 32'(3'b001));
        m_update(v);

        // RX CMD 0x4D while the PHY owns the bus with nxt low.
        v = '0;
        drive(v); m_update(v);
        v.dir = 1'b1; v.din = 8'h00;
        drive(v); m_update(v);
        v.din = 8'h4D;
        drive(v);
        check("rxcmd_before", 32'(bus.rx_cmd_valid), 32'(0));
        m_update(v);
        v.nxt = 1'b1; v.din = 8'h11;
        drive(v);
        check("rxcmd_valid", 32'(bus.rx_cmd_valid), 32'(RXEN));
        check("rxcmd_value", 32'(bus.rx_cmd), RXEN ? 32'h4D : 32'h00);
        m_update(v);
        v = '0;
        drive(v);
        check("rxcmd_one_cycle", 32'(bus.rx_cmd_valid), 32'(0));
        m_update(v);
        drive(v); m_update(v);

        // Randomised PHY behaviour against the model, in segments of differing PHY temperament.
        for (int seg = 0; seg < 4; seg++) begin
            int dir_den;
            int nxt_den;
            case (seg)
                0:       begin dir_den = 6;  nxt_den = 2;  end
                1:       begin dir_den = 30; nxt_den = 3;  end
                2:       begin dir_den = 0;  nxt_den = 2;  end
                default: begin dir_den = 50; nxt_den = 90; end
            endcase
            for (int c = 0; c < 600; c++) begin
                v.rst       = ($urandom_range(399, 0) == 0);
                v.req_valid = $urandom_range(1, 0) == 1;
                v.wr        = $urandom_range(1, 0) == 1;
                v.addr      = 6'($urandom);
                v.wdata     = 8'($urandom);
                v.din       = 8'($urandom);
                v.nxt       = ($urandom_range(nxt_den - 1, 0) == 0);
                if (dir_den == 0) v.dir = 1'b0;
                else if ($urandom_range(dir_den - 1, 0) == 0) v.dir = !v.dir;
                drive(v);
                o = sample();
                e = m_expect(v);
                check($sformatf("rand_s%0d_c%0d", seg, c), 32'(o), 32'(e));
                m_update(v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ulpi_link_reg.md
ULPI_LINK_REG -- requirements
Module: ulpi_link_reg

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles waiting for ulpi_nxt or turnaround before abort.
REQ-002 ulpi_clk  input  1  ULPI 60 MHz clock; single clock domain.
REQ-003 ulpi_reset  input  1  reset, synchronous, active-high.
REQ-004 ulpi_data_in  input  8  ULPI bus value sampled from PHY.
REQ-005 ulpi_data_out  output  8  value link drives onto ULPI bus.
REQ-006 ulpi_data_oe  output  1  link bus drive enable.
REQ-007 ulpi_direction  input  1  PHY owns bus when high.
REQ-008 ulpi_nxt  input  1  PHY throttle/accept strobe.
REQ-009 ulpi_stp  output  1  link stop strobe.
REQ-010 req_valid / req_ready  input / output  1 / 1  register-access request handshake.
REQ-011 req_wr  input  1  1 = register write, 0 = register read.
REQ-012 req_addr  input  6  immediate register address.
REQ-013 req_wdata  input  8  write data.
REQ-014 rsp_valid  output  1  one-cycle completion pulse per accepted request.
REQ-015 rsp_rdata / rsp_err  output  8 / 1  read data (0 on writes/errors); timeout flag.
REQ-016 rx_cmd_valid / rx_cmd  output  1 / 8  RX CMD byte strobe and value.

Function
REQ-017 States: IDLE, CMD, WDATA, STP, TURN, RDATA, WAIT_LOW, HOLD; all registered.
REQ-018 ulpi_data_oe = !ulpi_direction && !dir_d (dir_d = ulpi_direction registered); combinational, so bus is released in the cycle dir rises and after dir falls for one turnaround cycle.
REQ-019 req_ready = 1 only in IDLE with ulpi_direction=0 and dir_d=0; on req_valid&&req_ready latch wr/addr/wdata, go CMD.
REQ-020 IDLE: ulpi_data_out = 8'h00 (NOOP), ulpi_stp = 0.
REQ-021 CMD: ulpi_data_out = {wr ? 2'b10 : 2'b11, addr}, held until ulpi_nxt=1; then write -> WDATA, read -> TURN.
REQ-022 WDATA: drive wdata, held until ulpi_nxt=1 -> STP.
REQ-023 STP: ulpi_stp=1, data 8'h00 for exactly one cycle; rsp_valid=1, rsp_err=0; -> IDLE.
REQ-024 TURN: wait ulpi_direction=1 -> RDATA; RDATA: register ulpi_data_in as rsp_rdata, pulse rsp_valid -> WAIT_LOW; WAIT_LOW -> IDLE when ulpi_direction=0.
REQ-025 Abort: ulpi_direction=1 in CMD or WDATA with ulpi_nxt=0 -> HOLD; HOLD returns to CMD (full reissue) one cycle after dir falls; no rsp for aborted attempt.
REQ-026 Timeout: counter clears on each state entry; TIMEOUT_CYCLES cycles in CMD/WDATA/TURN -> rsp_valid=1, rsp_err=1, rsp_rdata=0; write path via STP, read path -> WAIT_LOW.
REQ-027 Exactly one rsp_valid per accepted request; no new request accepted before rsp_valid.

Reset
REQ-028 On ulpi_reset: state IDLE, ulpi_stp=0, ulpi_data_out=8'h00, rsp_valid=0, rsp_err=0, rsp_rdata=0, rx_cmd_valid=0, rx_cmd=0, dir_d=0, counter 0.
REQ-029 Reset mid-transfer drops the pending request silently; no rsp_valid issued.

Configuration
REQ-030 Macro ULPI_LINK_RXCMD_EN defined: when dir_d=1, ulpi_direction=1, ulpi_nxt=0 and state not RDATA, register ulpi_data_in into rx_cmd with rx_cmd_valid=1 for that cycle.
REQ-031 Macro undefined: rx_cmd_valid and rx_cmd tied to 0; no RX CMD logic synthesized.

Structure
REQ-032 Package ulpi_pkg holds state enum, TX CMD prefixes (REGW 2'b10, REGR 2'b11), NOOP 8'h00.
REQ-033 One sub-module: ulpi_timeout_cnt (clear/enable/expired, width from TIMEOUT_CYCLES).

Verification
REQ-034 Write addr 0x0A data 0x5A, PHY nxt high in CMD and WDATA -> bus 0x8A then 0x5A, one-cycle stp, rsp_valid, rsp_err=0.
REQ-035 Read addr 0x16, PHY turnaround then drives 0xC3 -> bus 0xD6, oe low when dir high, rsp_rdata=0xC3.
REQ-036 dir rises during CMD before nxt -> HOLD, CMD 0xD6 reissued after dir falls, single rsp_valid.
REQ-037 nxt never asserted on write -> after 64 cycles stp pulse, rsp_valid with rsp_err=1.
REQ-038 With ULPI_LINK_RXCMD_EN, PHY drives RX CMD 0x4D -> rx_cmd_valid one cycle, rx_cmd=0x4D; without macro never asserted.
REQ-039 ulpi_reset asserted in WDATA -> next cycle IDLE, stp=0, no rsp_valid, req_ready=1.
